range_window_ctrl: RTL and testbench
====================================

// Module: range_window_ctrl
// PURPOSE
//   Sequencer in front of the RangeFinder datapath. Accepts a valid/ready sample stream and cuts it
//   into windows of win_len samples. Per window it drives RangeFinder's go/finish/data, captures the
//   range (max-min) or error, and returns one result per window on a valid/ready output.
//   Sits between the chip pads / sample source and a single RangeFinder instance.
// PARAMETERS
//   WIDTH     8    sample and range width (matches RangeFinder WIDTH)
//   LEN_W     8    width of window-length config
//   TIMEOUT   255  max consecutive no-sample cycles in RUN before the window is aborted
// PORTS
//   clk        in   1      rising-edge clock
//   rst_n      in   1      synchronous active-low reset
//   win_len    in   LEN_W  samples per window; latched on the first sample of each window
//   s_data     in   WIDTH  sample in
//   s_valid    in   1      sample valid
//   s_ready    out  1      controller accepts sample (transfer = s_valid & s_ready)
//   m_range    out  WIDTH  window result (0 when m_error=1)
//   m_error    out  1      window failed (RangeFinder error or stall timeout)
//   m_valid    out  1      result valid, held until m_ready
//   m_ready    in   1      result consumer ready
//   rf_data    out  WIDTH  to RangeFinder data_in
//   rf_go      out  1      to RangeFinder go
//   rf_finish  out  1      to RangeFinder finish
//   rf_range   in   WIDTH  from RangeFinder range; valid the cycle after rf_finish
//   rf_error   in   1      from RangeFinder error
//   busy       out  1      high in any state but IDLE
// BEHAVIOUR
//   Reset (rst_n=0 at a clk edge): state=IDLE. All outputs 0 except s_ready=1.
//     Applies mid-window too. Window is discarded; no result is emitted.
//   States: IDLE, RUN, WAIT_RES, HOLD.
//   IDLE: s_ready=1. On the first transfer: latch len=max(win_len,2), cnt=1,
//     rf_data=s_data, rf_go=1 for that one cycle. Go to RUN.
//   RUN: s_ready=1. Each transfer: rf_data<=s_data, cnt++.
//     Cycles with no transfer: rf_data holds the last sample. A repeat cannot change max/min.
//     Transfer with cnt+1==len: rf_finish=1 for that cycle, go to WAIT_RES.
//   WAIT_RES (1 cycle): s_ready=0. Capture rf_range and rf_error into m_range/m_error.
//     Set m_valid. Go to HOLD.
//     Latency: last sample at cycle T -> m_valid=1 at T+2.
//   HOLD: s_ready=0. m_valid, m_range and m_error are stable until m_valid&m_ready.
//     Then clear m_valid and go to IDLE. Back-to-back windows: next window's go no earlier than 1 cycle after accept.
//   Error: rf_error=1 in RUN -> abort: rf_finish=0, m_error=1, m_range=0, go to HOLD.
//   Stall: in RUN, stall counter clears on every transfer. Counter reaching TIMEOUT -> same abort path.
//     RangeFinder is restarted by the next go.
//   rf_go and rf_finish are never high in the same cycle. Each is a single-cycle pulse per window.
//   win_len changes mid-window are ignored. win_len 0 or 1 is treated as 2.
//   cnt is LEN_W+1 bits wide; no wrap for len=2^LEN_W-1.
// STRUCTURE
//   rf_ctrl_pkg: state_t enum {IDLE,RUN,WAIT_RES,HOLD}; MIN_LEN=2 constant.
//   Sub-module range_stall_timer: counter with clear, enable and expired outputs, parameterised by TIMEOUT.
//   FSM, sample counter and output registers stay in range_window_ctrl.
// TESTING
//   1. win_len=4, samples 10,3,250,7 back-to-back, m_ready=1 -> rf_go at 10, rf_finish at 7.
//      m_range=247, m_error=0 two cycles after 7.
//   2. Same window with s_valid gaps of 1-3 cycles -> rf_data held across gaps; m_range=247.
//   3. m_ready=0 for 10 cycles after the result -> m_valid and m_range stable, s_ready=0.
//      Accept -> IDLE, next window starts.
//   4. win_len=0 and win_len=1 -> window closes after 2 samples.
//      Samples 5,9 -> m_range=4.
//   5. Force rf_error=1 mid-window -> m_valid=1, m_error=1, m_range=0; no rf_finish pulse.
//      Stall of TIMEOUT cycles in RUN -> same response.
//   6. rst_n=0 for one cycle during RUN -> next cycle IDLE, busy=0, m_valid=0.
//      No stale result; the following window is correct.

Source files
------------

// File: rtl/rf_ctrl_pkg.sv
// rf_ctrl_pkg: shared state encoding and constants for the range window sequencer
package rf_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, RUN, WAIT_RES, HOLD} state_t;
    localparam int MIN_LEN = 2;
endpackage

// File: rtl/range_stall_timer.sv
// range_stall_timer: counts idle cycles and flags when TIMEOUT consecutive ones have elapsed
module range_stall_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] cnt_q, cnt_d;
    assign expired_o = cnt_q == TW'(TIMEOUT);
    // saturate at TIMEOUT so the expired flag stays asserted until cleared
    always_comb cnt_d = clr_i ? '0 : (en_i && !expired_o) ? cnt_q + 1'b1 : cnt_q;
    // counter register
    always_ff @(posedge clk) cnt_q <= !rst_n ? '0 : cnt_d;
endmodule

// File: rtl/range_window_ctrl.sv
// range_window_ctrl: cuts a sample stream into windows and sequences one RangeFinder per window
module range_window_ctrl
    import rf_ctrl_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int LEN_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LEN_W-1:0] win_len,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] m_range,
    output logic             m_error,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] rf_data,
    output logic             rf_go,
    output logic             rf_finish,
    input  logic [WIDTH-1:0] rf_range,
    input  logic             rf_error,
    output logic             busy
);
    localparam int CNT_W = LEN_W + 1;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] len_q, len_d, cnt_q, cnt_d;
    logic [WIDTH-1:0] data_q, data_d, range_q, range_d;
    logic             err_q, err_d, valid_q, valid_d;
    logic             xfer, expired, abort;
    logic [CNT_W-1:0] win_len_ext;

    assign win_len_ext = {1'b0, win_len};
    assign s_ready     = state_q == IDLE || state_q == RUN;
    assign xfer        = s_valid && s_ready;
    assign abort       = state_q == RUN && (rf_error || expired);
    // the accepted sample goes straight through so go/finish see it in the same cycle
    assign rf_data     = xfer ? s_data : data_q;
    assign rf_go       = state_q == IDLE && xfer;
    assign rf_finish   = state_q == RUN && xfer && !abort && cnt_q + 1'b1 == len_q;
    assign busy        = state_q != IDLE;
    assign m_range     = range_q;
    assign m_error     = err_q;
    assign m_valid     = valid_q;

    range_stall_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (state_q != RUN || xfer),
        .en_i     (1'b1),
        .expired_o(expired)
    );

    // next-state, window bookkeeping and result capture
    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        data_d  = xfer ? s_data : data_q;
        range_d = range_q;
        err_d   = err_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: if (xfer) begin
                len_d   = win_len_ext < CNT_W'(MIN_LEN) ? CNT_W'(MIN_LEN) : win_len_ext;
                cnt_d   = CNT_W'(1);
                state_d = RUN;
            end
            RUN: if (abort) begin
                range_d = '0;
                err_d   = 1'b1;
                valid_d = 1'b1;
                state_d = HOLD;
            end else if (xfer) begin
                cnt_d   = cnt_q + 1'b1;
                state_d = rf_finish ? WAIT_RES : RUN;
            end
            WAIT_RES: begin
                range_d = rf_range;
                err_d   = rf_error;
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: if (m_ready) begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // state and datapath registers; reset discards any window in progress
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            range_q <= '0;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            range_q <= range_d;
            err_q   <= err_d;
            valid_q <= valid_d;
        end
    end
endmodule

// File: tb/tb_range_window_ctrl.sv
// tb_range_window_ctrl: directed checks of the window sequencer against a RangeFinder stand-in
module tb_range_window_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic [7:0] win_len = 8'd4, s_data = 8'd0;
    logic       s_valid = 1'b0, m_ready = 1'b1, rf_error = 1'b0;
    logic       s_ready, m_error, m_valid, rf_go, rf_finish, busy;
    logic [7:0] m_range, rf_data, rf_range;
    logic [7:0] mx = 8'd0, mn = 8'd0, rng = 8'd0;
    int         fin_cnt = 0;
    int         total = 0, fails = 0;
    int         f0, n;

    always #5 clk = ~clk;

    range_window_ctrl dut (
        .clk(clk), .rst_n(rst_n), .win_len(win_len), .s_data(s_data), .s_valid(s_valid),
        .s_ready(s_ready), .m_range(m_range), .m_error(m_error), .m_valid(m_valid),
        .m_ready(m_ready), .rf_data(rf_data), .rf_go(rf_go), .rf_finish(rf_finish),
        .rf_range(rf_range), .rf_error(rf_error), .busy(busy)
    );

    // RangeFinder stand-in: tracks max/min from go, range valid the cycle after finish
    assign rf_range = rng;
    always @(posedge clk) begin
        if (rf_go) begin
            mx <= rf_data;
            mn <= rf_data;
        end else begin
            if (rf_data > mx) mx <= rf_data;
            if (rf_data < mn) mn <= rf_data;
        end
        if (rf_finish) begin
            rng     <= (rf_data > mx ? rf_data : mx) - (rf_data < mn ? rf_data : mn);
            fin_cnt <= fin_cnt + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic exp_go, input logic exp_fin);
        s_data  = d;
        s_valid = 1'b1;
        @(negedge clk);
        chk("rf_go", rf_go, exp_go);
        chk("rf_finish", rf_finish, exp_fin);
        chk("rf_data", rf_data, d);
        cyc();
        s_valid = 1'b0;
    endtask

    task automatic wait_result(input logic [7:0] r, input logic e);
        @(negedge clk);
        chk("wait_res_valid", m_valid, 1'b0);
        chk("wait_res_sready", s_ready, 1'b0);
        cyc();
        @(negedge clk);
        chk("res_valid", m_valid, 1'b1);
        chk("res_range", m_range, r);
        chk("res_error", m_error, e);
    endtask

    initial begin
        logic [7:0] d [4];
        int         g [3];
        d = '{8'd10, 8'd3, 8'd250, 8'd7};
        g = '{1, 3, 2};
        cyc();
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_sready", s_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mvalid", m_valid, 1'b0);
        chk("rst_mrange", m_range, 8'd0);
        chk("rst_merror", m_error, 1'b0);
        chk("rst_go_fin", {rf_go, rf_finish}, 2'b00);
        cyc();
        // back-to-back window
        send(8'd10, 1'b1, 1'b0);
        send(8'd3, 1'b0, 1'b0);
        send(8'd250, 1'b0, 1'b0);
        send(8'd7, 1'b0, 1'b1);
        wait_result(8'd247, 1'b0);
        cyc();
        @(negedge clk);
        chk("t1_idle_busy", busy, 1'b0);
        chk("t1_idle_valid", m_valid, 1'b0);
        cyc();
        // same window with gaps: data must be held while s_valid is low
        for (int i = 0; i < 4; i++) begin
            send(d[i], i == 0, i == 3);
            if (i < 3)
                for (int k = 0; k < g[i]; k++) begin
                    @(negedge clk);
                    chk("t2_gap_data", rf_data, d[i]);
                    chk("t2_gap_go_fin", {rf_go, rf_finish}, 2'b00);
                    cyc();
                end
        end
        wait_result(8'd247, 1'b0);
        cyc();
        // consumer back-pressure
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) send(d[i], i == 0, i == 3);
        wait_result(8'd247, 1'b0);
        for (int i = 0; i < 10; i++) begin
            cyc();
            @(negedge clk);
            chk("t3_hold_valid", m_valid, 1'b1);
            chk("t3_hold_range", m_range, 8'd247);
            chk("t3_hold_sready", s_ready, 1'b0);
        end
        m_ready = 1'b1;
        cyc();
        @(negedge clk);
        chk("t3_accept_busy", busy, 1'b0);
        chk("t3_accept_valid", m_valid, 1'b0);
        cyc();
        // short lengths clamp to 2; mid-window win_len change ignored
        win_len = 8'd0;
        send(8'd5, 1'b1, 1'b0);
        win_len = 8'd4;
        send(8'd9, 1'b0, 1'b1);
        wait_result(8'd4, 1'b0);
        cyc();
        win_len = 8'd1;
        send(8'd5, 1'b1, 1'b0);
        send(8'd9, 1'b0, 1'b1);
        wait_result(8'd4, 1'b0);
        cyc();
        // stall timeout aborts the window
        win_len = 8'd4;
        f0 = fin_cnt;
        send(8'd10, 1'b1, 1'b0);
        n = 0;
        while (!m_valid && n < 400) begin
            n++;
            cyc();
        end
        chk("t5_stall_cycles", n, 256);
        chk("t5_stall_error", m_error, 1'b1);
        chk("t5_stall_range", m_range, 8'd0);
        chk("t5_stall_nofin", fin_cnt, f0);
        cyc();
        // reset mid-window discards it; next window is clean
        send(8'd10, 1'b1, 1'b0);
        send(8'd3, 1'b0, 1'b0);
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_valid", m_valid, 1'b0);
        chk("t6_rst_sready", s_ready, 1'b1);
        cyc();
        send(8'd5, 1'b1, 1'b0);
        send(8'd9, 1'b0, 1'b0);
        send(8'd20, 1'b0, 1'b0);
        send(8'd100, 1'b0, 1'b1);
        wait_result(8'd95, 1'b0);
        cyc();
        // RangeFinder error aborts without a finish pulse
        f0 = fin_cnt;
        send(8'd10, 1'b1, 1'b0);
        send(8'd3, 1'b0, 1'b0);
        rf_error = 1'b1;
        @(negedge clk);
        chk("t5_err_nofin", rf_finish, 1'b0);
        cyc();
        rf_error = 1'b0;
        @(negedge clk);
        chk("t5_err_valid", m_valid, 1'b1);
        chk("t5_err_error", m_error, 1'b1);
        chk("t5_err_range", m_range, 8'd0);
        chk("t5_err_fincnt", fin_cnt, f0);
        cyc();
        @(negedge clk);
        chk("t5_err_idle", busy, 1'b0);
        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end
endmodule
